axi_rd_arbiter_2x1: RTL and testbench
=====================================

Name: axi_rd_arbiter_2x1

Overview:
- Hand-written 2-to-1 AXI4 read-channel arbiter for the CPU top level.
- Shares the single external AR/R port between the data cache (port s0) and the instruction cache (port s1).
- Allows one outstanding burst at a time; the R beats are steered back to the port that won the grant.
- Write channels are not handled here: only the dcache writes, and its AW/W/B channels connect straight to the external port.

Parameters:
- D_PRIO, 1, 1 = the dcache wins whenever both ports request; 0 = round-robin between the two ports.
- ARBURST_VAL, 2'b01, constant driven on m_arburst (INCR).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- s0_araddr / s1_araddr  input  32  read address from the dcache / icache.
- s0_arlen / s1_arlen  input  8  burst length minus 1.
- s0_arsize / s1_arsize  input  3  bytes per beat.
- s0_arvalid / s1_arvalid  input  1  read request valid.
- s0_arready / s1_arready  output  1  request accepted.
- s0_rdata / s1_rdata  output  32  read data.
- s0_rresp / s1_rresp  output  2  read response.
- s0_rlast / s1_rlast  output  1  last beat of the burst.
- s0_rvalid / s1_rvalid  output  1  read data valid.
- s0_rready / s1_rready  input  1  cache ready to take data.
- m_araddr, m_arlen, m_arsize  output  32/8/3  request fields of the granted port.
- m_arburst  output  2  constant ARBURST_VAL.
- m_arid  output  4  constant 4'b0.
- m_arvalid  output  1  external request valid.
- m_arready  input  1  external slave accepted the address.
- m_rdata, m_rresp, m_rlast  input  32/2/1  external read data.
- m_rvalid  input  1  external data valid.
- m_rready  output  1  ready, taken from the granted port.
- grant  output  1  0 = dcache owns the bus, 1 = icache owns the bus (debug).
- busy  output  1  FSM is not in R_IDLE.

Behaviour:
- Reset state: FSM = R_IDLE, grant = 0, last_grant = 1.
  - All valid and ready outputs are 0; m_araddr, m_arlen and m_arsize are 0.
  - Reset asserted mid-burst abandons the burst immediately; any R beats still arriving are not accepted.
- R_IDLE:
  - All s*_arready = 0, all s*_rvalid = 0, m_arvalid = 0, m_rready = 0.
  - If any s*_arvalid = 1, register the grant and move to R_ADDR.
  - Only one port requesting: that port wins.
  - Both requesting with D_PRIO = 1: s0 wins.
  - Both requesting with D_PRIO = 0: the winner is ~last_grant.
- R_ADDR:
  - m_ar* fields and m_arvalid are driven combinationally from the granted port.
  - s[grant]_arready = m_arready; the other port's arready = 0.
  - On m_arvalid & m_arready, move to R_DATA.
  - A requester that withdraws arvalid after the grant is a protocol violation. The FSM stays in R_ADDR; no recovery is provided.
- R_DATA:
  - s[grant]_rvalid/rdata/rresp/rlast = m_r* (combinational, zero added latency).
  - m_rready = s[grant]_rready. The non-granted port sees rvalid = 0 and rdata = 0.
  - On m_rvalid & m_rready & m_rlast: set last_grant = grant and return to R_IDLE.
  - m_rvalid while the FSM is in R_IDLE or R_ADDR is ignored (m_rready = 0).
- Latency:
  - A request first seen in R_IDLE on cycle N drives m_arvalid on cycle N+1.
  - The next arbitration can occur no earlier than the cycle after the rlast handshake, so there is one idle bubble between bursts.
- Outputs during R_IDLE and R_ADDR:
  - busy = 1 in every state except R_IDLE.
  - grant holds its value in R_IDLE; it changes only on the transition out of R_IDLE.
- Bursts are never interleaved and the arbiter never pre-empts a burst. Burst length is unrestricted up to 256 beats.

Test Plan:
- Single dcache request, araddr = 0x1FC0_0040, arlen = 7; slave sets arready after 2 cycles and returns 8 beats 0xA0..0xA7 → s0 receives 8 beats with rlast on 0xA7, s1_rvalid stays 0, busy drops the cycle after rlast.
- Both ports request in the same cycle with D_PRIO = 1 → dcache is served first (grant = 0); icache is granted right after the dcache burst's rlast (one idle bubble) and completes.
- D_PRIO = 0, both ports request continuously for 4 bursts → grants alternate 0, 1, 0, 1 starting from 0 (last_grant = 1 after reset).
- Backpressure: s1_rready toggles every cycle during a 4-beat burst → m_rready mirrors it and no beat is lost or duplicated (data 0x11..0x14 arrives in order).
- Reset asserted after beat 2 of an 8-beat burst → the next edge finds FSM = R_IDLE, all ready/valid outputs 0 and grant = 0; a new dcache request afterwards completes normally.
- Spurious m_rvalid = 1 while in R_IDLE → m_rready = 0, no s*_rvalid asserted, FSM remains in R_IDLE.

Source files
------------

// File: rtl/axi_rd_arbiter_2x1_if.sv
// axi_rd_arbiter_2x1_if: AXI4 read address/data channel bundle for one port
interface axi_rd_arbiter_2x1_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    modport master (
        output araddr, arlen, arsize, arburst, arid, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter_2x1.sv
// axi_rd_arbiter_2x1: shares one AXI4 read port between dcache (s0) and icache (s1),
// one outstanding burst at a time with R beats steered back to the granted port.
module axi_rd_arbiter_2x1 #(
    parameter bit         D_PRIO      = 1'b1,
    parameter logic [1:0] ARBURST_VAL = 2'b01
) (
    input  logic                         clk,
    input  logic                         rst,
    axi_rd_arbiter_2x1_if.slave          s0,
    axi_rd_arbiter_2x1_if.slave          s1,
    axi_rd_arbiter_2x1_if.master         m,
    output logic                         grant,
    output logic                         busy
);
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} state_t;
    state_t state;
    logic   last_grant;
    logic   pick;
    logic   in_addr;
    logic   in_data;
    always_comb begin
        pick    = (s0.arvalid & s1.arvalid) ? (D_PRIO ? 1'b0 : ~last_grant) : s1.arvalid;
        in_addr = state == R_ADDR;
        in_data = state == R_DATA;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= R_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                R_IDLE: if (s0.arvalid | s1.arvalid) begin
                    grant <= pick;
                    state <= R_ADDR;
                    busy  <= 1'b1;
                end
                R_ADDR: if (m.arvalid & m.arready) state <= R_DATA;
                R_DATA: if (m.rvalid & m.rready & m.rlast) begin
                    last_grant <= grant;
                    state      <= R_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= R_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
    // Address channel: fields are zero outside R_ADDR so the bus is quiet when idle
    assign m.araddr  = in_addr ? (grant ? s1.araddr : s0.araddr) : '0;
    assign m.arlen   = in_addr ? (grant ? s1.arlen : s0.arlen) : '0;
    assign m.arsize  = in_addr ? (grant ? s1.arsize : s0.arsize) : '0;
    assign m.arvalid = in_addr & (grant ? s1.arvalid : s0.arvalid);
    assign m.arburst = ARBURST_VAL;
    assign m.arid    = '0;
    assign s0.arready = in_addr & ~grant & m.arready;
    assign s1.arready = in_addr & grant & m.arready;
    assign m.rready  = in_data & (grant ? s1.rready : s0.rready);
    assign s0.rvalid = in_data & ~grant & m.rvalid;
    assign s0.rdata  = (in_data & ~grant) ? m.rdata : '0;
    assign s0.rresp  = (in_data & ~grant) ? m.rresp : '0;
    assign s0.rlast  = in_data & ~grant & m.rlast;
    assign s1.rvalid = in_data & grant & m.rvalid;
    assign s1.rdata  = (in_data & grant) ? m.rdata : '0;
    assign s1.rresp  = (in_data & grant) ? m.rresp : '0;
    assign s1.rlast  = in_data & grant & m.rlast;
endmodule

// File: tb/tb_axi_rd_arbiter_2x1.sv
// tb_axi_rd_arbiter_2x1: drives both D_PRIO variants with shared stimulus and checks
// the selected one against a transaction-level model of the arbitration rules.
module tb_axi_rd_arbiter_2x1;
    typedef struct packed {
        logic        s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast;
        logic [1:0]  s0_rresp, s1_rresp;
        logic [31:0] s0_rdata, s1_rdata, m_araddr;
        logic [7:0]  m_arlen;
        logic [2:0]  m_arsize;
        logic [1:0]  m_arburst;
        logic [3:0]  m_arid;
        logic        m_arvalid, m_rready, grant, busy;
    } obs_t;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a0, a1, m_rdata;
    logic [7:0]  l0, l1;
    logic [2:0]  z0, z1;
    logic        v0, v1, rr0, rr1, m_arready, m_rvalid, m_rlast;
    logic [1:0]  m_rresp;
    logic        dp;
    obs_t        o;
    int          vectors = 0;
    int          miscompares = 0;
    logic        last_w;
    logic        exp_grant;
    int          cfg_dly, cfg_dbase, cfg_rr, cfg_abort;
    always #5 clk = ~clk;
    for (genvar k = 0; k < 2; k++) begin : g
        axi_rd_arbiter_2x1_if s0_if ();
        axi_rd_arbiter_2x1_if s1_if ();
        axi_rd_arbiter_2x1_if m_if ();
        logic gr, bz;
        obs_t ob;
        assign s0_if.araddr  = a0;
        assign s0_if.arlen   = l0;
        assign s0_if.arsize  = z0;
        assign s0_if.arburst = '0;
        assign s0_if.arid    = '0;
        assign s0_if.arvalid = v0;
        assign s0_if.rready  = rr0;
        assign s1_if.araddr  = a1;
        assign s1_if.arlen   = l1;
        assign s1_if.arsize  = z1;
        assign s1_if.arburst = '0;
        assign s1_if.arid    = '0;
        assign s1_if.arvalid = v1;
        assign s1_if.rready  = rr1;
        assign m_if.arready  = m_arready;
        assign m_if.rdata    = m_rdata;
        assign m_if.rresp    = m_rresp;
        assign m_if.rlast    = m_rlast;
        assign m_if.rvalid   = m_rvalid;
        axi_rd_arbiter_2x1 #(.D_PRIO(k == 1), .ARBURST_VAL(2'b01)) dut (
            .clk(clk), .rst(rst), .s0(s0_if), .s1(s1_if), .m(m_if), .grant(gr), .busy(bz)
        );
        assign ob = '{s0_arready: s0_if.arready, s1_arready: s1_if.arready,
                      s0_rvalid: s0_if.rvalid, s1_rvalid: s1_if.rvalid,
                      s0_rlast: s0_if.rlast, s1_rlast: s1_if.rlast,
                      s0_rresp: s0_if.rresp, s1_rresp: s1_if.rresp,
                      s0_rdata: s0_if.rdata, s1_rdata: s1_if.rdata,
                      m_araddr: m_if.araddr, m_arlen: m_if.arlen, m_arsize: m_if.arsize,
                      m_arburst: m_if.arburst, m_arid: m_if.arid, m_arvalid: m_if.arvalid,
                      m_rready: m_if.rready, grant: gr, busy: bz};
    end
    assign o = dp ? g[1].ob : g[0].ob;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, o.busy, 0);
        chk({tag, "_m_arvalid"}, o.m_arvalid, 0);
        chk({tag, "_m_rready"}, o.m_rready, 0);
        chk({tag, "_s0_arready"}, o.s0_arready, 0);
        chk({tag, "_s1_arready"}, o.s1_arready, 0);
        chk({tag, "_s0_rvalid"}, o.s0_rvalid, 0);
        chk({tag, "_s1_rvalid"}, o.s1_rvalid, 0);
    endtask

    task automatic do_burst(input logic r0, input logic r1, input bit rnd);
        logic w, rr, wv;
        int   dly, n, got, t;
        if (rnd && r0 && !v0) begin a0 = $urandom; l0 = 8'($urandom_range(0, 7)); z0 = 3'($urandom_range(0, 2)); end
        if (rnd && r1 && !v1) begin a1 = $urandom; l1 = 8'($urandom_range(0, 7)); z1 = 3'($urandom_range(0, 2)); end
        v0 = r0; v1 = r1;
        m_arready = 1'b0; m_rlast = 1'b0; m_rdata = $urandom;
        m_rvalid = rnd ? 1'($urandom) : 1'b0;
        rr0 = 1'($urandom); rr1 = 1'($urandom);
        #1;
        chk_idle("idle");
        chk("grant_hold", o.grant, exp_grant);
        w = (r0 & r1) ? (dp ? 1'b0 : ~last_w) : r1;
        tick();
        dly = cfg_dly < 0 ? $urandom_range(0, 3) : cfg_dly;
        for (int i = 0; i <= dly; i++) begin
            m_arready = (i == dly);
            m_rvalid = rnd ? 1'($urandom) : 1'b0;
            #1;
            chk("grant", o.grant, w);
            chk("busy_addr", o.busy, 1);
            chk("m_arvalid", o.m_arvalid, 1);
            chk("m_araddr", o.m_araddr, w ? a1 : a0);
            chk("m_arlen", o.m_arlen, w ? l1 : l0);
            chk("m_arsize", o.m_arsize, w ? z1 : z0);
            chk("m_arburst", o.m_arburst, 1);
            chk("m_arid", o.m_arid, 0);
            chk("s0_arready", o.s0_arready, !w && m_arready);
            chk("s1_arready", o.s1_arready, w && m_arready);
            chk("m_rready_addr", o.m_rready, 0);
            chk("rvalid_addr", {o.s0_rvalid, o.s1_rvalid}, 0);
            tick();
        end
        m_arready = 1'b0;
        if (w) v1 = 1'b0; else v0 = 1'b0;
        n = int'(w ? l1 : l0) + 1;
        got = 0;
        rr = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (rnd) repeat ($urandom_range(0, 2)) begin
                m_rvalid = 1'b0; rr0 = 1'($urandom); rr1 = 1'($urandom);
                #1;
                chk("rvalid_gap", {o.s0_rvalid, o.s1_rvalid}, 0);
                chk("busy_gap", o.busy, 1);
                tick();
            end
            m_rvalid = 1'b1;
            m_rdata = cfg_dbase < 0 ? $urandom : cfg_dbase + b;
            m_rresp = 2'($urandom);
            m_rlast = (b == n - 1);
            t = 0;
            do begin
                rr = (t == 7 || cfg_rr == 1) ? 1'b1 : cfg_rr == 2 ? ~rr : 1'($urandom);
                if (w) begin rr1 = rr; rr0 = 1'($urandom); end
                else begin rr0 = rr; rr1 = 1'($urandom); end
                #1;
                wv = w ? o.s1_rvalid : o.s0_rvalid;
                chk("m_rready", o.m_rready, rr);
                chk("w_rvalid", wv, 1);
                chk("w_rdata", w ? o.s1_rdata : o.s0_rdata, m_rdata);
                chk("w_rlast", w ? o.s1_rlast : o.s0_rlast, m_rlast);
                chk("w_rresp", w ? o.s1_rresp : o.s0_rresp, m_rresp);
                chk("other_rvalid", w ? o.s0_rvalid : o.s1_rvalid, 0);
                chk("other_rdata", w ? o.s0_rdata : o.s1_rdata, 0);
                if (wv && rr) got++;
                t++;
                tick();
            end while (!rr);
            if (b + 1 == cfg_abort) begin
                rst = 1'b1;
                #1;
                chk_idle("rst_async");
                chk("rst_grant", o.grant, 0);
                chk("rst_m_araddr", o.m_araddr, 0);
                tick();
                chk_idle("rst_edge");
                rst = 1'b0;
                m_rvalid = 1'b0; m_rlast = 1'b0; v0 = 1'b0; v1 = 1'b0;
                last_w = 1'b1; exp_grant = 1'b0;
                return;
            end
        end
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        chk("beats", got, n);
        last_w = w;
        exp_grant = w;
    endtask

    task automatic rand_burst();
        logic r0, r1;
        r0 = v0 | 1'($urandom);
        r1 = v1 | 1'($urandom);
        if (!r0 && !r1) begin r1 = 1'($urandom); r0 = ~r1; end
        do_burst(r0, r1, 1'b1);
    endtask

    initial begin
        dp = 1'b1;
        a0 = '0; a1 = '0; l0 = '0; l1 = '0; z0 = '0; z1 = '0;
        v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0; m_rresp = '0;
        cfg_dly = -1; cfg_dbase = -1; cfg_rr = 0; cfg_abort = -1;
        rst = 1'b1;
        #1;
        chk_idle("reset");
        chk("reset_grant", o.grant, 0);
        chk("reset_m_araddr", o.m_araddr, 0);
        chk("reset_m_arlen", o.m_arlen, 0);
        chk("reset_m_arsize", o.m_arsize, 0);
        tick();
        tick();
        rst = 1'b0;
        last_w = 1'b1;
        exp_grant = 1'b0;
        m_rvalid = 1'b1; m_rlast = 1'b1;
        repeat (3) begin
            #1;
            chk_idle("spurious");
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        a0 = 32'h1FC0_0040; l0 = 8'd7; z0 = 3'd2;
        cfg_dly = 2; cfg_dbase = 'hA0; cfg_rr = 1;
        do_burst(1'b1, 1'b0, 1'b0);
        a0 = 32'h0000_2000; l0 = 8'd3; a1 = 32'h0000_1000; l1 = 8'd1;
        cfg_dly = 0; cfg_dbase = -1;
        do_burst(1'b1, 1'b1, 1'b0);
        do_burst(1'b0, 1'b1, 1'b0);
        a1 = 32'h0000_3000; l1 = 8'd3; cfg_dbase = 'h11; cfg_rr = 2;
        do_burst(1'b0, 1'b1, 1'b0);
        a0 = 32'h0000_4000; l0 = 8'd7; cfg_dbase = -1; cfg_rr = 1; cfg_abort = 2;
        do_burst(1'b1, 1'b0, 1'b0);
        cfg_abort = -1;
        a0 = 32'h0000_5000; l0 = 8'd2;
        do_burst(1'b1, 1'b0, 1'b0);
        cfg_dly = -1; cfg_rr = 0;
        repeat (30) rand_burst();
        dp = 1'b0;
        rst = 1'b1;
        v0 = 0; v1 = 0; m_rvalid = 0; m_rlast = 0;
        tick();
        rst = 1'b0;
        last_w = 1'b1;
        exp_grant = 1'b0;
        l0 = 8'd1; l1 = 8'd1; cfg_dly = 0; cfg_rr = 1;
        repeat (4) do_burst(1'b1, 1'b1, 1'b0);
        cfg_dly = -1; cfg_rr = 0;
        repeat (30) rand_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
